// File: rtl/cordic_scheduler.sv
// Round-robin front end for one shared, free-running CORDIC sin/cos pipeline.
// A {valid,id} tag line runs alongside the pipeline latency. Results land in
// a credit-protected FIFO whose head is held in output registers.
module cordic_scheduler #(
  parameter int N_REQ      = 4,
  parameter int ID_W       = 2,
  parameter int LAT        = 16,
  parameter int FIFO_DEPTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*32-1:0]  req_angle,
  output logic [N_REQ-1:0]     req_ready,
  output logic [31:0]          cordic_angle,
  input  logic [31:0]          cordic_cos,
  input  logic [31:0]          cordic_sin,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ID_W-1:0]      res_id,
  output logic [31:0]          res_cos,
  output logic [31:0]          res_sin,
  output logic                 busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  // The head register holds one entry, so the body needs one slot fewer.
  localparam int BODY  = FIFO_DEPTH - 1;
  localparam int PTR_W = (BODY > 1) ? $clog2(BODY) : 1;
  localparam int ENT_W = ID_W + 64;

  logic [ID_W-1:0]  last_q;
  logic             found_s;
  logic [ID_W-1:0]  grant_s;
  logic             credit_ok_s;
  logic             xfer_s;
  logic [ID_W:0]    tag_q [LAT];
  logic [CNT_W-1:0] in_flight_q, in_flight_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0] body_cnt_s;
  logic [ENT_W-1:0] mem_q [BODY];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic             push_s, pop_s, head_load_s;
  logic [ENT_W-1:0] push_data_s, head_data_d;
  logic             head_valid_d, rd_adv_s, mem_wr_s;
  logic             res_valid_q, busy_q;
  logic [ID_W-1:0]  res_id_q;
  logic [31:0]      res_cos_q, res_sin_q;

  // Wrap-around increment for the non power-of-two body pointers.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BODY - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int idx;
    idx     = 0;
    found_s = 1'b0;
    grant_s = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_q) + k) % N_REQ;
      if (!found_s && req_valid[idx]) begin
        found_s = 1'b1;
        grant_s = ID_W'(idx);
      end
    end
  end

  // Credit check: every issued angle must already own a FIFO slot.
  assign credit_ok_s = ({1'b0, in_flight_q} + {1'b0, fifo_cnt_q}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign xfer_s      = found_s & credit_ok_s & ~rst;
  assign req_ready   = xfer_s ? (N_REQ'(1) << grant_s) : '0;
  assign cordic_angle = xfer_s ? req_angle[32*grant_s +: 32] : 32'sd0;

  assign push_s      = tag_q[LAT-1][ID_W];
  assign push_data_s = {tag_q[LAT-1][ID_W-1:0], cordic_cos, cordic_sin};
  assign pop_s       = res_valid_q & res_ready;
  assign head_load_s = ~res_valid_q | pop_s;
  assign body_cnt_s  = fifo_cnt_q - CNT_W'(res_valid_q);

  // Head refill: body first (keeps order), else bypass the fresh capture.
  always_comb begin
    head_valid_d = res_valid_q;
    head_data_d  = {res_id_q, res_cos_q, res_sin_q};
    rd_adv_s     = 1'b0;
    mem_wr_s     = 1'b0;
    if (head_load_s) begin
      if (body_cnt_s != '0) begin
        head_valid_d = 1'b1;
        head_data_d  = mem_q[rd_ptr_q];
        rd_adv_s     = 1'b1;
        mem_wr_s     = push_s;
      end else if (push_s) begin
        head_valid_d = 1'b1;
        head_data_d  = push_data_s;
      end else begin
        head_valid_d = 1'b0;
      end
    end else begin
      mem_wr_s = push_s;
    end
  end

  // Occupancy bookkeeping for in-flight tags and FIFO entries.
  always_comb begin
    case ({xfer_s, push_s})
      2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
      2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
      default: in_flight_d = in_flight_q;
    endcase
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Control state: RR pointer, tag line, counters, pointers and head registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= ID_W'(N_REQ - 1);
      for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
      in_flight_q <= '0;
      fifo_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_cos_q   <= 32'd0;
      res_sin_q   <= 32'd0;
      busy_q      <= 1'b0;
    end else begin
      if (xfer_s) last_q <= grant_s;
      tag_q[0] <= {xfer_s, grant_s};
      for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
      in_flight_q <= in_flight_d;
      fifo_cnt_q  <= fifo_cnt_d;
      if (rd_adv_s) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (mem_wr_s) wr_ptr_q <= ptr_inc(wr_ptr_q);
      res_valid_q <= head_valid_d;
      {res_id_q, res_cos_q, res_sin_q} <= head_data_d;
      busy_q <= (in_flight_d != '0) | (fifo_cnt_d != '0);
    end
  end

  // Body storage; contents are meaningful only between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (mem_wr_s) mem_q[wr_ptr_q] <= push_data_s;
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_cos   = res_cos_q;
  assign res_sin   = res_sin_q;
  assign busy      = busy_q;

endmodule
